alu_mc_hs: RTL and testbench
============================

// Module: alu_mc_hs
// PURPOSE
//  Parametrised multi-cycle ALU for the pipeline EX stage; successor to the single-cycle Alu.
//  Keeps the Alu operand/result names (A, B, ALU_Sel, ALU_Out, coutfin, z) and registers its result.
//  Adds a valid/ready handshake, iterative multiply and optional iterative unsigned divide.
//  The hazard unit stalls upstream while in_ready=0.
// PARAMETERS
//  WIDTH     32  operand/result width in bits (>=8, power of 2)
//  MUL_BITS  1   multiplier bits retired per CALC cycle; WIDTH % MUL_BITS == 0
// PORTS
//  clk        in   1      single clock, all state on posedge
//  rst_n      in   1      synchronous active-low reset
//  in_valid   in   1      operands/op valid
//  in_ready   out  1      block can accept; =1 only in IDLE and rst_n=1
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B (shift amount = B[$clog2(WIDTH)-1:0])
//  ALU_Sel    in   4      opcode, see BEHAVIOUR
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes result
//  ALU_Out    out  WIDTH  registered result
//  coutfin    out  1      registered carry: ADD carry-out, SUB no-borrow, else 0
//  z          out  1      registered (ALU_Out == 0)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, out_valid=0, ALU_Out=0, coutfin=0, z=0, partial regs cleared;
//   aborts any op in flight, no result emitted; in_ready=0 while rst_n=0.
//  Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB (A+~B+1), 0111 SLT (signed, 0/1),
//   1000 SLTU, 1001 SLL, 1010 SRL, 1011 SRA, 1100 MUL (low WIDTH), 1101 MULHU (high WIDTH, unsigned),
//   1110 DIVU, 1111 REMU; undefined codes (0100,0101) -> ALU_Out=0, coutfin=0.
//  Accept = in_valid & in_ready; A, B, ALU_Sel captured on accept; later input changes ignored.
//  FSM: IDLE --accept, single-cycle op--> DONE (result computed and registered at accept edge)
//       IDLE --accept, MUL/MULHU/DIVU/REMU--> CALC
//       CALC --step counter hits last step--> DONE
//       DONE --out_ready--> IDLE
//  out_valid=1 exactly in DONE; ALU_Out/coutfin/z stable in DONE until out_ready (backpressure, any length).
//  Latency accept->out_valid: 1 cycle single-cycle ops; WIDTH/MUL_BITS+1 MUL/MULHU; WIDTH+1 DIVU/REMU.
//  Throughput: max one op per 2 cycles (no accept in DONE, even with out_ready=1).
//  MUL: unsigned shift-add over 2*WIDTH product; MUL and MULHU identical latency.
//  DIVU: restoring, 1 quotient bit per cycle. B=0: DIVU -> all ones, REMU -> A, full latency kept.
//  ADD/SUB arithmetic in WIDTH+1 bits, bit WIDTH -> coutfin; overflow wraps modulo 2^WIDTH.
//  SRA sign-fills from A[WIDTH-1]; shift amount 0 returns A unchanged.
//  z derived from the registered result, valid together with out_valid.
// CONFIGURATION
//  ALU_DIV_EN defined: divider datapath present; 1110/1111 as above, latency WIDTH+1.
//  ALU_DIV_EN undefined: no divider logic; 1110/1111 single-cycle, ALU_Out=0, coutfin=0, z=1.
// TESTING (WIDTH=32, MUL_BITS=1)
//  ADD A=ABCDEFFF B=12345678 -> ALU_Out=BE024677, coutfin=0, z=0, out_valid 1 cycle after accept.
//  SUB A=5 B=5 -> ALU_Out=0, z=1, coutfin=1; SLT A=FFFFFFFF B=1 -> 1; SLTU same -> 0; SRA 80000000>>4 -> F8000000.
//  MUL A=FFFFFFFF B=2 -> FFFFFFFE; MULHU -> 00000001; out_valid 33 cycles after accept, in_ready=0 throughout.
//  out_ready=0 for 5 cycles in DONE -> ALU_Out/z/coutfin constant, in_ready=0, in_valid ignored; release -> IDLE next cycle.
//  rst_n=0 at 10th CALC cycle of MUL -> next edge out_valid=0, ALU_Out=0; in_ready=1 first cycle after release; no stale result.
//  ALU_DIV_EN on: DIVU 64/7 -> 9, REMU -> 1, DIVU x/0 -> FFFFFFFF, REMU 40/0 -> 40; off: DIVU -> 0, z=1, 1-cycle latency.

Source files
------------

// File: rtl/alu_mc_hs.sv
// Multi-cycle EX-stage ALU with valid/ready handshake, iterative multiply and optional divide.
// Define ALU_DIV_EN to build the restoring divider for DIVU/REMU.
module alu_mc_hs #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             coutfin,
  output logic             z
);

  localparam int unsigned SHW       = $clog2(WIDTH);
  localparam int unsigned CNTW      = $clog2(WIDTH);
  localparam int unsigned MUL_STEPS = WIDTH / MUL_BITS;
  localparam int unsigned PW        = WIDTH + MUL_BITS;
  localparam int unsigned DW        = 2 * WIDTH;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             is_multi;
  logic             last_step;

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opb;
  logic [CNTW-1:0]  cnt;
  logic             sel_hi_q;
`ifdef ALU_DIV_EN
  logic             div_q;
`endif

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c;

  logic [PW-1:0]    mul_pp;
  logic [PW-1:0]    mul_sum;
  logic [DW-1:0]    mul_next;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH-1:0] calc_res;

  // Multiply/divide run in CALC; everything else completes at the accept edge.
`ifdef ALU_DIV_EN
  assign is_multi = (ALU_Sel[3:2] == 2'b11);
`else
  assign is_multi = (ALU_Sel[3:1] == 3'b110);
`endif

  assign accept = in_valid & in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = is_multi ? S_CALC : S_DONE;
        end
      end
      S_CALC: begin
        if (last_step) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (rst_n && (state == S_IDLE)) begin
      in_ready = 1'b1;
    end
    if (state == S_DONE) begin
      out_valid = 1'b1;
    end
  end

  // Single-cycle datapath; SUB carry is the no-borrow flag of A + ~B + 1
  always_comb begin
    shamt  = B[SHW-1:0];
    add_w  = {1'b0, A} + {1'b0, B};
    sub_w  = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
    sc_res = '0;
    sc_c   = 1'b0;
    case (ALU_Sel)
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_ADD: begin
        sc_res = add_w[WIDTH-1:0];
        sc_c   = add_w[WIDTH];
      end
      OP_XOR:  sc_res = A ^ B;
      OP_SUB: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_c   = sub_w[WIDTH];
      end
      OP_SLT:  sc_res = WIDTH'($signed(A) < $signed(B));
      OP_SLTU: sc_res = WIDTH'(A < B);
      OP_SLL:  sc_res = A << shamt;
      OP_SRL:  sc_res = A >> shamt;
      OP_SRA:  sc_res = WIDTH'($signed(A) >>> shamt);
      default: sc_res = '0;
    endcase
  end

  // Shift-add step: hi accumulates, lo holds the unconsumed multiplier bits
  always_comb begin
    mul_pp = '0;
    for (int i = 0; i < int'(MUL_BITS); i++) begin
      if (lo[i]) begin
        mul_pp = mul_pp + (PW'(opb) << i);
      end
    end
    mul_sum  = PW'(hi) + mul_pp;
    mul_next = DW'({mul_sum, lo} >> MUL_BITS);
  end

`ifdef ALU_DIV_EN
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  // Restoring step: hi is the partial remainder, lo shifts dividend out and quotient in
  always_comb begin
    rem_sh   = {hi, lo[WIDTH-1]};
    div_ge   = (rem_sh >= {1'b0, opb});
    div_diff = rem_sh - {1'b0, opb};
    div_hi   = div_ge ? WIDTH'(div_diff) : WIDTH'(rem_sh);
    div_lo   = {lo[WIDTH-2:0], div_ge};
  end
`endif

  always_comb begin
    step_hi   = mul_next[DW-1:WIDTH];
    step_lo   = mul_next[WIDTH-1:0];
    last_step = (cnt == CNTW'(MUL_STEPS - 1));
`ifdef ALU_DIV_EN
    if (div_q) begin
      step_hi   = div_hi;
      step_lo   = div_lo;
      last_step = (cnt == CNTW'(WIDTH - 1));
    end
`endif
    calc_res = sel_hi_q ? step_hi : step_lo;
  end

  // Operand capture, iteration registers and registered result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ALU_Out  <= '0;
      coutfin  <= 1'b0;
      z        <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      opb      <= '0;
      cnt      <= '0;
      sel_hi_q <= 1'b0;
`ifdef ALU_DIV_EN
      div_q    <= 1'b0;
`endif
    end else if (accept) begin
      cnt      <= '0;
      hi       <= '0;
      sel_hi_q <= ALU_Sel[0];
      if (is_multi) begin
`ifdef ALU_DIV_EN
        div_q <= ALU_Sel[1];
        lo    <= ALU_Sel[1] ? A : B;
        opb   <= ALU_Sel[1] ? B : A;
`else
        lo    <= B;
        opb   <= A;
`endif
      end else begin
        ALU_Out <= sc_res;
        coutfin <= sc_c;
        z       <= (sc_res == '0);
      end
    end else if (state == S_CALC) begin
      cnt <= cnt + CNTW'(1);
      hi  <= step_hi;
      lo  <= step_lo;
      if (last_step) begin
        ALU_Out <= calc_res;
        coutfin <= 1'b0;
        z       <= (calc_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_mc_hs.sv
// Scoreboard bench for alu_mc_hs (WIDTH=32, MUL_BITS=1); honours ALU_DIV_EN if defined.
module tb_alu_mc_hs;

  localparam int unsigned W = 32;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        zz;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  s;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [3:0]  op_sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] alu_out;
  logic        coutfin;
  logic        z;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  alu_mc_hs #(.WIDTH(W), .MUL_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(op_a), .B(op_b), .ALU_Sel(op_sel), .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Out(alu_out), .coutfin(coutfin), .z(z)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    exp_t        e;
    logic [63:0] p;
    logic [32:0] t;
    e.res = '0;
    e.c   = 1'b0;
    e.lat = 1;
    p = {32'b0, a} * {32'b0, b};
    t = {1'b0, a} + {1'b0, b};
    case (s)
      4'h0: e.res = a & b;
      4'h1: e.res = a | b;
      4'h2: begin e.res = t[31:0]; e.c = t[32]; end
      4'h3: e.res = a ^ b;
      4'h6: begin e.res = a - b; e.c = (a >= b); end
      4'h7: e.res = {31'b0, ($signed(a) < $signed(b))};
      4'h8: e.res = {31'b0, (a < b)};
      4'h9: e.res = a << b[4:0];
      4'hA: e.res = a >> b[4:0];
      4'hB: e.res = $signed(a) >>> b[4:0];
      4'hC: begin e.res = p[31:0];  e.lat = 33; end
      4'hD: begin e.res = p[63:32]; e.lat = 33; end
`ifdef ALU_DIV_EN
      4'hE: begin e.res = (b == 0) ? 32'hFFFFFFFF : a / b; e.lat = 33; end
      4'hF: begin e.res = (b == 0) ? a : a % b;            e.lat = 33; end
`endif
      default: e.res = '0;
    endcase
    e.zz = (e.res == 32'h0);
    return e;
  endfunction

  // Drives one transaction, scrambles inputs after accept, returns observed result and latency
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [3:0] is,
                        output logic [31:0] r, output logic rc, output logic rz,
                        output int lat, output bit busy_rdy);
    int w;
    w = 0;
    busy_rdy = 1'b0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    sb.push_back(model(ia, ib, is));
    op_a = ia; op_b = ib; op_sel = is; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom; op_sel = 4'h2;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_rdy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    r = alu_out; rc = coutfin; rz = z;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; op_sel = 4'h2; op_a = 32'h1; op_b = 32'h1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_vec++;
    if ({alu_out, coutfin, z} !== 34'h0) begin
      n_err++; $display("FAIL reset_result got %h c=%b z=%b want 0/0/0", alu_out, coutfin, z);
    end
    in_valid = 1'b0; rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_idle_valid got %b want 0", out_valid); end
  endtask

  task automatic test_single();
    vec_t        tbl[16];
    logic [3:0]  ops[10];
    logic [31:0] r;
    logic        rc, rz;
    int          lat;
    bit          br;
    exp_t        e;
    vec_t        v;
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
    tbl = '{
      '{32'hABCDEFFF, 32'h12345678, 4'h2}, '{32'h00000005, 32'h00000005, 4'h6},
      '{32'hFFFFFFFF, 32'h00000001, 4'h7}, '{32'hFFFFFFFF, 32'h00000001, 4'h8},
      '{32'h80000000, 32'h00000004, 4'hB}, '{32'hFFFFFFFF, 32'h00000001, 4'h2},
      '{32'hF0F0F0F0, 32'h0FF00FF0, 4'h0}, '{32'hF0F0F0F0, 32'h0FF00FF0, 4'h1},
      '{32'hF0F0F0F0, 32'h0FF00FF0, 4'h3}, '{32'h00000001, 32'h0000003F, 4'h9},
      '{32'h80000000, 32'h0000001F, 4'hA}, '{32'h92345678, 32'hFFFFFFE0, 4'hB},
      '{32'h00000003, 32'h00000005, 4'h6}, '{32'h00000005, 32'h00000003, 4'h4},
      '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'h5}, '{32'h00000001, 32'h80000000, 4'h7}
    };
    for (int i = 0; i < 16 + 12; i++) begin
      if (i < 16) v = tbl[i];
      else begin
        v.a = $urandom; v.b = $urandom; v.s = ops[$urandom_range(0, 9)];
      end
      run_op(v.a, v.b, v.s, r, rc, rz, lat, br);
      e = sb.pop_front();
      n_vec++;
      if ({r, rc, rz} !== {e.res, e.c, e.zz}) begin
        n_err++;
        $display("FAIL single op=%h a=%h b=%h got %h c=%b z=%b want %h c=%b z=%b",
                 v.s, v.a, v.b, r, rc, rz, e.res, e.c, e.zz);
      end
      n_vec++;
      if (lat !== e.lat) begin
        n_err++; $display("FAIL single_latency op=%h got %0d want %0d", v.s, lat, e.lat);
      end
    end
  endtask

  task automatic test_mul();
    vec_t        tbl[6];
    logic [31:0] r;
    logic        rc, rz;
    int          lat;
    bit          br;
    exp_t        e;
    vec_t        v;
    tbl = '{
      '{32'hFFFFFFFF, 32'h00000002, 4'hC}, '{32'hFFFFFFFF, 32'h00000002, 4'hD},
      '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'hC}, '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'hD},
      '{32'h00000000, 32'h12345678, 4'hD}, '{32'h00010000, 32'h00010000, 4'hC}
    };
    for (int i = 0; i < 6 + 4; i++) begin
      if (i < 6) v = tbl[i];
      else begin
        v.a = $urandom; v.b = $urandom; v.s = (i % 2 == 0) ? 4'hC : 4'hD;
      end
      run_op(v.a, v.b, v.s, r, rc, rz, lat, br);
      e = sb.pop_front();
      n_vec++;
      if ({r, rc, rz} !== {e.res, e.c, e.zz}) begin
        n_err++;
        $display("FAIL mul op=%h a=%h b=%h got %h c=%b z=%b want %h c=%b z=%b",
                 v.s, v.a, v.b, r, rc, rz, e.res, e.c, e.zz);
      end
      n_vec++;
      if (lat !== e.lat) begin
        n_err++; $display("FAIL mul_latency op=%h got %0d want %0d", v.s, lat, e.lat);
      end
      n_vec++;
      if (br !== 1'b0) begin
        n_err++; $display("FAIL mul_busy_ready op=%h in_ready seen 1 want 0 while busy", v.s);
      end
    end
  endtask

  task automatic test_div();
    vec_t        tbl[6];
    logic [31:0] r;
    logic        rc, rz;
    int          lat;
    bit          br;
    exp_t        e;
    vec_t        v;
    tbl = '{
      '{32'd64, 32'd7, 4'hE}, '{32'd64, 32'd7, 4'hF},
      '{32'h87654321, 32'h0, 4'hE}, '{32'h00000040, 32'h0, 4'hF},
      '{32'hFFFFFFFF, 32'h00000001, 4'hE}, '{32'h00000003, 32'h80000000, 4'hF}
    };
    for (int i = 0; i < 6 + 4; i++) begin
      if (i < 6) v = tbl[i];
      else begin
        v.a = $urandom; v.b = $urandom >> $urandom_range(0, 28); v.s = (i % 2 == 0) ? 4'hE : 4'hF;
      end
      run_op(v.a, v.b, v.s, r, rc, rz, lat, br);
      e = sb.pop_front();
      n_vec++;
      if ({r, rc, rz} !== {e.res, e.c, e.zz}) begin
        n_err++;
        $display("FAIL div op=%h a=%h b=%h got %h c=%b z=%b want %h c=%b z=%b",
                 v.s, v.a, v.b, r, rc, rz, e.res, e.c, e.zz);
      end
      n_vec++;
      if (lat !== e.lat) begin
        n_err++; $display("FAIL div_latency op=%h got %0d want %0d", v.s, lat, e.lat);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   w;
    bit   seen;
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    out_ready = 1'b0;
    sb.push_back(model(32'hABCDEFFF, 32'h12345678, 4'h2));
    op_a = 32'hABCDEFFF; op_b = 32'h12345678; op_sel = 4'h2; in_valid = 1'b1;
    @(posedge clk); #1;
    op_a = 32'h5; op_b = 32'h5; op_sel = 4'h6;
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if ({out_valid, in_ready} !== 2'b10) begin
        n_err++; $display("FAIL bp_handshake cyc=%0d got valid=%b ready=%b want 1/0", i, out_valid, in_ready);
      end
      n_vec++;
      if ({alu_out, coutfin, z} !== {e.res, e.c, e.zz}) begin
        n_err++; $display("FAIL bp_hold cyc=%0d got %h c=%b z=%b want %h c=%b z=%b",
                          i, alu_out, coutfin, z, e.res, e.c, e.zz);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    in_valid = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL bp_ignored_input got out_valid=1 want 0"); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops[10];
    exp_t       e;
    bit         acc;
    int         k, got, cyc, last;
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
    k = 0; got = 0; cyc = 0; last = 0;
    out_ready = 1'b1;
    op_a = $urandom; op_b = $urandom; op_sel = ops[$urandom_range(0, 9)];
    sb.push_back(model(op_a, op_b, op_sel));
    in_valid = 1'b1;
    while (got < 6 && cyc < 40) begin
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (out_valid) begin
        e = sb.pop_front();
        n_vec++;
        if ({alu_out, coutfin, z} !== {e.res, e.c, e.zz}) begin
          n_err++; $display("FAIL b2b_result n=%0d got %h c=%b z=%b want %h c=%b z=%b",
                            got, alu_out, coutfin, z, e.res, e.c, e.zz);
        end
        got++;
        last = cyc;
      end
      if (acc) begin
        k++;
        if (k < 6) begin
          op_a = $urandom; op_b = $urandom; op_sel = ops[$urandom_range(0, 9)];
          sb.push_back(model(op_a, op_b, op_sel));
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    n_vec++;
    if (got !== 6 || last !== 11) begin
      n_err++; $display("FAIL b2b_throughput got %0d results by cycle %0d want 6 by cycle 11", got, last);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    logic [31:0] r;
    logic        rc, rz;
    int          lat;
    bit          br, stale;
    exp_t        e;
    run_op(32'hABCDEFFF, 32'h12345678, 4'h2, r, rc, rz, lat, br);
    e = sb.pop_front();
    n_vec++;
    if (r !== e.res) begin n_err++; $display("FAIL midrst_pre got %h want %h", r, e.res); end
    op_a = 32'hFFFFFFFF; op_b = 32'h2; op_sel = 4'hC; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, in_ready, alu_out} !== 34'h0) begin
      n_err++; $display("FAIL midrst_abort got valid=%b ready=%b out=%h want 0/0/0", out_valid, in_ready, alu_out);
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready got %b want 1", in_ready); end
    stale = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    n_vec++;
    if (stale !== 1'b0) begin n_err++; $display("FAIL midrst_stale got out_valid=1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mul();
    test_div();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
